// File: rtl/program_sequencer_if.sv
// program_sequencer_if: host/execute-side bundle of the program sequencer (load stream, run control, fetch outputs)
interface program_sequencer_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        run_start;
  logic        halt_req;
  logic        step_req;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        fault;
  modport master (
    output load_valid, load_data, load_last, run_start, halt_req, step_req,
    input  load_ready, instruction, instr_valid, pc, state, fault
  );
  modport slave (
    input  load_valid, load_data, load_last, run_start, halt_req, step_req,
    output load_ready, instruction, instr_valid, pc, state, fault
  );
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: program memory + PC owner; load/run/pause/step/fault sequencing. Optional macro ECALL_HALT_EN turns ecall into a breakpoint.
module program_sequencer #(
  parameter int          MEM_DEPTH = 32,
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic reset,
  program_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_STEP, S_FAULT} state_t;
  state_t            r_state, w_next;
  logic [31:0]       r_mem [MEM_DEPTH];
  logic [31:0]       r_pc;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_load_count;
  logic [31:0]       w_instr, w_jal_off;
  logic              w_fetch, w_illegal, w_jal, w_ecall, w_load_hs, w_load_end, w_start, w_exec;
  assign w_instr    = r_mem[r_pc[ADDR_W+1:2]];
  assign w_fetch    = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_illegal  = (r_pc[31:2] >= 30'(r_load_count)) || (r_pc[1:0] != 2'b00);
  assign w_jal      = w_instr[6:0] == 7'b1101111;
  assign w_jal_off  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
`ifdef ECALL_HALT_EN
  assign w_ecall    = w_instr[6:0] == 7'b1110011;
`else
  assign w_ecall    = 1'b0;
`endif
  assign w_load_hs  = (r_state == S_LOAD) && bus.load_valid;
  assign w_load_end = w_load_hs && (bus.load_last || r_wr_ptr == ADDR_W'(MEM_DEPTH - 1));
  assign w_start    = (r_state == S_IDLE) && bus.run_start && (r_load_count != '0);
  // an illegal fetch or a breakpoint suppresses execution of the presented word
  assign w_exec     = w_fetch && !w_illegal && !w_ecall;
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? S_IDLE : w_next;
  // next state: fault check outranks ecall/halt; step outranks run in PAUSE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_RUN : bus.load_valid ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = w_load_end ? S_IDLE : S_LOAD;
      S_RUN:   w_next = w_illegal ? S_FAULT : (w_ecall || bus.halt_req) ? S_PAUSE : S_RUN;
      S_STEP:  w_next = w_illegal ? S_FAULT : S_PAUSE;
      S_PAUSE: w_next = bus.step_req ? S_STEP : bus.run_start ? S_RUN : S_PAUSE;
      default: w_next = S_FAULT;
    endcase
  end
  // outputs decoded from state and fetch legality
  always_comb begin
    bus.load_ready  = r_state == S_LOAD;
    bus.instr_valid = w_exec;
    bus.fault       = r_state == S_FAULT;
    bus.state       = r_state;
    bus.pc          = r_pc;
    bus.instruction = w_instr;
  end
  // pc, write pointer and program length; ecall still advances pc past itself
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_wr_ptr     <= '0;
      r_load_count <= '0;
    end else begin
      if (w_start)
        r_pc <= RESET_PC;
      else if (w_fetch && !w_illegal)
        r_pc <= (w_jal && !w_ecall) ? r_pc + w_jal_off : r_pc + 32'd4;
      if (w_load_hs)
        r_wr_ptr <= w_load_end ? '0 : r_wr_ptr + 1'b1;
      if (w_load_end)
        r_load_count <= {1'b0, r_wr_ptr} + 1'b1;
    end
  end
  // program memory is never cleared; a zero load_count makes stale words unreachable
  always_ff @(posedge clk)
    if (w_load_hs && !reset)
      r_mem[r_wr_ptr] <= bus.load_data;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed self-checking bench for program_sequencer
module tb_program_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  program_sequencer_if bus();
  program_sequencer dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  localparam logic [31:0] ADDI1 = 32'h00100093;
  localparam logic [31:0] ADDI2 = 32'h00200113;
  localparam logic [31:0] JALM8 = 32'hFF9FF06F;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] NOP   = 32'h00000013;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_run(input string tag, input logic [31:0] exp_pc, input logic exp_v);
    chk({tag, "_state"}, 32'(bus.state), 32'd2);
    chk({tag, "_pc"}, bus.pc, exp_pc);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'(exp_v));
  endtask
  initial begin
    bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
    bus.run_start = 0; bus.halt_req = 0; bus.step_req = 0;
    step(); step();
    reset = 0;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_ready", 32'(bus.load_ready), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    bus.run_start = 1; step(); bus.run_start = 0;
    chk("idle_run_empty", 32'(bus.state), 0);
    bus.load_valid = 1; bus.load_data = ADDI1; step();
    chk("enter_load", 32'(bus.state), 1);
    chk("load_ready", 32'(bus.load_ready), 1);
    step();
    bus.load_data = ADDI2; step();
    bus.load_data = JALM8; bus.load_last = 1; step();
    bus.load_valid = 0; bus.load_last = 0;
    chk("load3_done", 32'(bus.state), 0);
    chk("load3_ready", 32'(bus.load_ready), 0);
    bus.run_start = 1; step(); bus.run_start = 0;
    chk_run("run0", 0, 1);
    chk("instr0", bus.instruction, ADDI1);
    step(); chk_run("run4", 4, 1);
    chk("instr4", bus.instruction, ADDI2);
    step(); chk_run("run8", 8, 1);
    chk("instr8", bus.instruction, JALM8);
    step(); chk_run("jal0", 0, 1);
    step(); chk_run("wrap4", 4, 1);
    bus.halt_req = 1; step(); bus.halt_req = 0;
    chk("halt_state", 32'(bus.state), 3);
    chk("halt_pc", bus.pc, 8);
    chk("halt_valid", 32'(bus.instr_valid), 0);
    step();
    chk("pause_hold_pc", bus.pc, 8);
    bus.step_req = 1; step(); bus.step_req = 0;
    chk("step1_state", 32'(bus.state), 4);
    chk("step1_pc", bus.pc, 8);
    chk("step1_valid", 32'(bus.instr_valid), 1);
    step();
    chk("step1_pause", 32'(bus.state), 3);
    chk("step1_next_pc", bus.pc, 0);
    bus.step_req = 1; bus.run_start = 1; step();
    bus.step_req = 0; bus.run_start = 0;
    chk("step_wins", 32'(bus.state), 4);
    step();
    chk("step2_pc", bus.pc, 4);
    bus.run_start = 1; step(); bus.run_start = 0;
    chk_run("resume", 4, 1);
    step(); chk_run("resume8", 8, 1);
    reset = 1; step(); reset = 0;
    chk("midrun_rst_state", 32'(bus.state), 0);
    chk("midrun_rst_pc", bus.pc, 0);
    bus.run_start = 1; step(); bus.run_start = 0;
    chk("rst_count_zero", 32'(bus.state), 0);
    bus.load_valid = 1; step();
    bus.load_data = ADDI1; step();
    bus.load_data = ECALL; bus.load_last = 1; step();
    bus.load_valid = 0; bus.load_last = 0;
    chk("load2_done", 32'(bus.state), 0);
    bus.run_start = 1; step(); bus.run_start = 0;
    chk_run("f_run0", 0, 1);
    step();
    chk("ecall_instr", bus.instruction, ECALL);
`ifdef ECALL_HALT_EN
    chk_run("ecall_brk", 4, 0);
    step();
    chk("ecall_pause", 32'(bus.state), 3);
    chk("ecall_pc", bus.pc, 8);
    bus.run_start = 1; step(); bus.run_start = 0;
`else
    chk_run("ecall_exec", 4, 1);
    step();
`endif
    chk_run("fault_fetch", 8, 0);
    step();
    chk("fault_state", 32'(bus.state), 5);
    chk("fault_flag", 32'(bus.fault), 1);
    chk("fault_pc", bus.pc, 8);
    bus.run_start = 1; bus.step_req = 1; bus.load_valid = 1; step();
    bus.run_start = 0; bus.step_req = 0; bus.load_valid = 0;
    chk("fault_sticky", 32'(bus.state), 5);
    chk("fault_no_ready", 32'(bus.load_ready), 0);
    reset = 1; step(); reset = 0;
    chk("fault_cleared", 32'(bus.fault), 0);
    bus.load_valid = 1; step();
    for (int i = 0; i < 32; i++) begin
      bus.load_valid = 1; bus.load_data = NOP; step();
      chk("load32_state", 32'(bus.state), (i == 31) ? 32'd0 : 32'd1);
      bus.load_valid = 0; step();
    end
    chk("load32_idle", 32'(bus.state), 0);
    bus.run_start = 1; step(); bus.run_start = 0;
    chk_run("l32_run0", 0, 1);
    repeat (31) step();
    chk_run("l32_last", 124, 1);
    step();
    chk_run("l32_end", 128, 0);
    step();
    chk("l32_fault", 32'(bus.state), 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
